// File: rtl/axi_mem_check_master_if.sv
// AXI4 channel bundle used by the memory-check master; the wrapper ties off the
// size, burst type, strobe, id, lock, cache and prot fields.
interface axi_mem_check_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWLEN, AWVALID, input AWREADY,
    output WDATA, WLAST, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARLEN, ARVALID, input ARREADY,
    input RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWLEN, AWVALID, output AWREADY,
    input WDATA, WLAST, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARLEN, ARVALID, output ARREADY,
    output RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_mem_check_master.sv
// One-shot AXI4 traffic generator: writes an INCR burst of 1..N, reads it back
// and raises a sticky ERROR on any data, response or RLAST mismatch.
module axi_mem_check_master #(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        BURST_LEN = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  output logic                   ERROR,
  axi_mem_check_master_if.master axi
);

  // 9 bits so the beat index and its increment cover a 256-beat burst
  localparam int unsigned CNT_W = 9;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [7:0]       AX_LEN    = 8'(BURST_LEN - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]        state,    state_nxt;
  logic [CNT_W-1:0]  beat,     beat_nxt;
  logic              aw_valid, aw_valid_nxt;
  logic              w_valid,  w_valid_nxt;
  logic              w_last,   w_last_nxt;
  logic [DATA_W-1:0] w_data,   w_data_nxt;
  logic              b_ready,  b_ready_nxt;
  logic              ar_valid, ar_valid_nxt;
  logic              r_ready,  r_ready_nxt;
  logic              error_q,  error_nxt;
  logic              r_bad;

  assign axi.AWADDR  = BASE_ADDR;
  assign axi.AWLEN   = AX_LEN;
  assign axi.AWVALID = aw_valid;
  assign axi.WDATA   = w_data;
  assign axi.WLAST   = w_last;
  assign axi.WVALID  = w_valid;
  assign axi.BREADY  = b_ready;
  assign axi.ARADDR  = BASE_ADDR;
  assign axi.ARLEN   = AX_LEN;
  assign axi.ARVALID = ar_valid;
  assign axi.RREADY  = r_ready;
  assign ERROR       = error_q;

  // Read beat j must carry j+1, OKAY, and RLAST exactly on the final beat
  assign r_bad = (axi.RDATA != (DATA_W'(beat) + DATA_W'(1)))
              || (axi.RRESP != 2'b00)
              || (axi.RLAST != (beat == LAST_BEAT));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= S_IDLE;
      beat     <= '0;
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      w_last   <= 1'b0;
      w_data   <= '0;
      b_ready  <= 1'b0;
      ar_valid <= 1'b0;
      r_ready  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat     <= beat_nxt;
      aw_valid <= aw_valid_nxt;
      w_valid  <= w_valid_nxt;
      w_last   <= w_last_nxt;
      w_data   <= w_data_nxt;
      b_ready  <= b_ready_nxt;
      ar_valid <= ar_valid_nxt;
      r_ready  <= r_ready_nxt;
      error_q  <= error_nxt;
    end
  end

  // Next-state and next-output logic; every output leaves through a flop
  always_comb begin
    state_nxt    = state;
    beat_nxt     = beat;
    aw_valid_nxt = aw_valid;
    w_valid_nxt  = w_valid;
    w_last_nxt   = w_last;
    w_data_nxt   = w_data;
    b_ready_nxt  = b_ready;
    ar_valid_nxt = ar_valid;
    r_ready_nxt  = r_ready;
    error_nxt    = error_q;

    case (state)
      S_IDLE: begin
        state_nxt    = S_AW;
        aw_valid_nxt = 1'b1;
      end
      S_AW: begin
        if (axi.AWREADY) begin
          aw_valid_nxt = 1'b0;
          w_valid_nxt  = 1'b1;
          w_data_nxt   = DATA_W'(1);
          w_last_nxt   = (LAST_BEAT == '0);
          beat_nxt     = '0;
          state_nxt    = S_W;
        end
      end
      S_W: begin
        if (axi.WREADY) begin
          if (beat == LAST_BEAT) begin
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            b_ready_nxt = 1'b1;
            state_nxt   = S_B;
          end else begin
            beat_nxt   = beat + CNT_W'(1);
            w_data_nxt = DATA_W'(beat) + DATA_W'(2);
            w_last_nxt = ((beat + CNT_W'(1)) == LAST_BEAT);
          end
        end
      end
      S_B: begin
        if (axi.BVALID) begin
          if (axi.BRESP != 2'b00) error_nxt = 1'b1;
          b_ready_nxt  = 1'b0;
          ar_valid_nxt = 1'b1;
          state_nxt    = S_AR;
        end
      end
      S_AR: begin
        if (axi.ARREADY) begin
          ar_valid_nxt = 1'b0;
          r_ready_nxt  = 1'b1;
          beat_nxt     = '0;
          state_nxt    = S_R;
        end
      end
      S_R: begin
        if (axi.RVALID) begin
          if (r_bad) error_nxt = 1'b1;
          if (beat == LAST_BEAT) begin
            r_ready_nxt = 1'b0;
            state_nxt   = S_DONE;
          end else begin
            beat_nxt = beat + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_mem_check_master.sv
// Directed bench for axi_mem_check_master against a small reactive memory slave
// with selectable backpressure and fault injection.
module tb_axi_mem_check_master;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int          LEN    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic error;

  always #5 clk = ~clk;

  axi_mem_check_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_mem_check_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(32'h0000_0000), .BURST_LEN(LEN)
  ) dut (
    .ACLK(clk), .ARESET(rst), .ERROR(error), .axi(bus)
  );

  // slave configuration, written only by the stimulus block
  int         w_mode = 0;
  int         ar_mode = 0;
  logic [1:0] bresp_cfg = 2'b00;
  bit         corrupt2 = 1'b0;
  bit         early_last = 1'b0;

  // slave state and observation counters
  int cyc, aw_cnt, ar_cnt, w_cnt, r_cnt, ridx;
  int w_bad, wlast_bad, addr_bad, drop_bad, w_early;
  bit b_pending, b_hs, r_hs, r_active;
  logic prev_aw, prev_w, prev_ar;
  logic [DATA_W-1:0] prev_wdata;
  logic [DATA_W-1:0] mem [0:LEN-1];

  int n_assert = 0;
  int n_fail   = 0;

  // Slave drives on the falling edge; a handshake seen here completes at the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      cyc = 0; aw_cnt = 0; ar_cnt = 0; w_cnt = 0; r_cnt = 0; ridx = 0;
      w_bad = 0; wlast_bad = 0; addr_bad = 0; drop_bad = 0; w_early = 0;
      b_pending = 0; b_hs = 0; r_hs = 0; r_active = 0;
      prev_aw = 0; prev_w = 0; prev_ar = 0; prev_wdata = '0;
      bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 2'b00;
      bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = '0; bus.RRESP = 2'b00; bus.RLAST = 0;
    end else begin
      cyc++;
      if (prev_aw && !bus.AWVALID) drop_bad++;
      if (prev_w && (!bus.WVALID || bus.WDATA != prev_wdata)) drop_bad++;
      if (prev_ar && !bus.ARVALID) drop_bad++;

      bus.AWREADY = (w_mode == 0) || (cyc % 3 == 2);
      if (bus.AWVALID && bus.AWREADY) begin
        aw_cnt++;
        if (bus.AWADDR != '0 || bus.AWLEN != 8'(LEN - 1)) addr_bad++;
      end
      prev_aw = bus.AWVALID && !bus.AWREADY;

      bus.WREADY = (w_mode == 0) || (cyc % 6 == 5);
      if (bus.WVALID && aw_cnt == 0) w_early++;
      if (bus.WVALID && bus.WREADY) begin
        if (w_cnt < LEN) mem[4'(w_cnt)] = bus.WDATA;
        if (bus.WDATA != DATA_W'(w_cnt + 1)) w_bad++;
        if (bus.WLAST != (w_cnt == LEN - 1)) wlast_bad++;
        if (bus.WLAST) b_pending = 1;
        w_cnt++;
      end
      prev_w = bus.WVALID && !bus.WREADY;
      prev_wdata = bus.WDATA;

      if (b_hs) begin
        bus.BVALID = 0; b_hs = 0;
      end else if (b_pending) begin
        bus.BVALID = 1; bus.BRESP = bresp_cfg; b_pending = 0;
      end
      if (bus.BVALID && bus.BREADY) b_hs = 1;

      if (r_hs) begin
        ridx++; r_hs = 0;
        if (ridx == LEN) r_active = 0;
      end
      if (r_active) begin
        bus.RVALID = 1;
        bus.RDATA  = mem[4'(ridx)] ^ ((corrupt2 && ridx == 2) ? DATA_W'(32'h80) : '0);
        bus.RRESP  = 2'b00;
        bus.RLAST  = early_last ? (ridx == LEN - 3) : (ridx == LEN - 1);
      end else begin
        bus.RVALID = 0; bus.RLAST = 0;
      end
      if (bus.RVALID && bus.RREADY) begin
        r_hs = 1; r_cnt++;
      end

      bus.ARREADY = (ar_mode == 0) || (cyc % 8 >= 6);
      if (bus.ARVALID && bus.ARREADY) begin
        ar_cnt++; r_active = 1; ridx = 0;
        if (bus.ARADDR != '0 || bus.ARLEN != 8'(LEN - 1)) addr_bad++;
      end
      prev_ar = bus.ARVALID && !bus.ARREADY;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [6:0] outs();
    return {bus.AWVALID, bus.WVALID, bus.WLAST, bus.BREADY, bus.ARVALID, bus.RREADY, error};
  endfunction

  // Reset for two edges, check reset outputs, release and check AWVALID one edge later
  task automatic apply_reset(input string tag);
    @(negedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk({tag, "_reset_outs"}, 64'(outs()), 64'd0);
    @(negedge clk); #1 rst = 1'b0;
    tick();
    chk({tag, "_awvalid_start"}, 64'(bus.AWVALID), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok = 0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (r_cnt == LEN && !bus.RREADY) begin ok = 1; break; end
    end
    chk({tag, "_done"}, 64'(ok), 64'd1);
    repeat (3) tick();
    chk({tag, "_done_idle"}, 64'(outs() & 7'b111_1110), 64'd0);
  endtask

  // which: 0 = B handshake pending, else read beat index (which-1) pending
  task automatic wait_evt(input string tag, input int which);
    bit ok = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk); #1;
      if (which == 0 ? b_hs : (r_hs && ridx == which - 1)) begin ok = 1; break; end
    end
    chk({tag, "_evt_seen"}, 64'(ok), 64'd1);
    chk({tag, "_err_before"}, 64'(error), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_err_after"}, 64'(error), 64'd1);
  endtask

  task automatic check_traffic(input string tag);
    chk({tag, "_aw_cnt"}, 64'(aw_cnt), 64'd1);
    chk({tag, "_ar_cnt"}, 64'(ar_cnt), 64'd1);
    chk({tag, "_w_cnt"}, 64'(w_cnt), 64'd16);
    chk({tag, "_wdata_bad"}, 64'(w_bad), 64'd0);
    chk({tag, "_wlast_bad"}, 64'(wlast_bad), 64'd0);
    chk({tag, "_addr_bad"}, 64'(addr_bad), 64'd0);
    chk({tag, "_valid_drop"}, 64'(drop_bad), 64'd0);
    chk({tag, "_w_before_aw"}, 64'(w_early), 64'd0);
  endtask

  initial begin
    // 1: always-ready slave, clean pass
    apply_reset("s1");
    wait_done("s1", 300);
    check_traffic("s1");
    chk("s1_mem0", 64'(mem[0]), 64'd1);
    chk("s1_mem15", 64'(mem[15]), 64'd16);
    chk("s1_error", 64'(error), 64'd0);

    // 2: heavy W and AR backpressure
    w_mode = 1; ar_mode = 1;
    apply_reset("s2");
    wait_done("s2", 500);
    check_traffic("s2");
    chk("s2_mem7", 64'(mem[7]), 64'd8);
    chk("s2_error", 64'(error), 64'd0);

    // 3: SLVERR write response, read phase still completes
    w_mode = 0; ar_mode = 0; bresp_cfg = 2'b10;
    apply_reset("s3");
    wait_evt("s3", 0);
    wait_done("s3", 300);
    chk("s3_r_cnt", 64'(r_cnt), 64'd16);
    repeat (5) tick();
    chk("s3_error_sticky", 64'(error), 64'd1);

    // 4: word at BASE_ADDR+8 corrupted on readback
    bresp_cfg = 2'b00; corrupt2 = 1'b1;
    apply_reset("s4");
    wait_evt("s4", 3);
    wait_done("s4", 300);
    chk("s4_error_sticky", 64'(error), 64'd1);

    // 5: RLAST on beat 14 of 16
    corrupt2 = 1'b0; early_last = 1'b1;
    apply_reset("s5");
    wait_evt("s5", 14);
    wait_done("s5", 300);
    chk("s5_error_sticky", 64'(error), 64'd1);

    // 6: one-cycle reset pulse in the middle of the W phase
    early_last = 1'b0; w_mode = 1;
    apply_reset("s6");
    begin
      bit ok = 0;
      for (int n = 0; n < 300; n++) begin
        tick();
        if (w_cnt == 5) begin ok = 1; break; end
      end
      chk("s6_reach_w5", 64'(ok), 64'd1);
    end
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("s6_abort_outs", 64'(outs()), 64'd0);
    @(negedge clk); #1 rst = 1'b0;
    tick();
    chk("s6_restart_aw", 64'(bus.AWVALID), 64'd1);
    wait_done("s6", 500);
    check_traffic("s6");
    chk("s6_error", 64'(error), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
